// File: rtl/irq_ctl_if.sv
// rtl/irq_ctl_if.sv - CPU bus snoop interface between the 65C02 bus and irq_ctl
interface irq_ctl_if;
    logic [15:0] AD;
    logic [7:0]  DO;
    logic        WE;
    logic        RDY;
    logic [7:0]  RD_DATA;
    logic        SEL;

    modport master (
        output AD,
        output DO,
        output WE,
        output RDY,
        input  RD_DATA,
        input  SEL
    );

    modport slave (
        input  AD,
        input  DO,
        input  WE,
        input  RDY,
        output RD_DATA,
        output SEL
    );
endinterface

// File: rtl/irq_ctl.sv
// rtl/irq_ctl.sv - memory-mapped IRQ/NMI controller for the 65C02; NMI path built with IRQ_CTL_NMI_EN
module irq_ctl #(
    parameter logic [15:0] BASE    = 16'hFE00,
    parameter logic [7:0]  NMI_LEN = 8'd4
) (
    input  logic        clk,
    input  logic        RST_N,
    irq_ctl_if.slave    bus,
    input  logic [7:0]  SRC,
    input  logic        NMI_SRC,
    output logic        IRQ,
    output logic        NMI
);

    localparam logic [1:0] OFF_PEND = 2'd0;
    localparam logic [1:0] OFF_ENA  = 2'd1;
    localparam logic [1:0] OFF_VEC  = 2'd2;
    localparam logic [1:0] OFF_CTRL = 2'd3;

    logic [7:0] src_s1_q, src_s2_q, src_s3_q;
    logic [7:0] pend_q, pend_d;
    logic [7:0] ena_q, ena_d;
    logic       gie_q, gie_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       sel_q, sel_d;
    logic       irq_q, irq_d;

    logic       hit;
    logic [1:0] off;
    logic       rd_stb;
    logic       wr_stb;
    logic [7:0] src_edge;
    logic [7:0] active;
    logic [7:0] vec;
    logic [7:0] rd_mux;

    assign hit      = (bus.AD[15:2] == BASE[15:2]);
    assign off      = bus.AD[1:0];
    assign rd_stb   = bus.RDY & ~bus.WE & hit;
    assign wr_stb   = bus.RDY &  bus.WE & hit;
    assign src_edge = src_s2_q & ~src_s3_q;
    assign active   = pend_q & ena_q;

    // Scan downward so the lowest active index wins.
    always_comb begin
        vec = 8'h80;
        for (int i = 7; i >= 0; i--) begin
            if (active[i]) begin
                vec = {5'b0, i[2:0]};
            end
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (off)
            OFF_PEND: rd_mux = pend_q;
            OFF_ENA:  rd_mux = ena_q;
            OFF_VEC:  rd_mux = vec;
            OFF_CTRL: rd_mux = {gie_q, 7'b0};
            default:  rd_mux = 8'h00;
        endcase
    end

    // A new edge wins over a simultaneous write-1-to-clear of the same bit.
    always_comb begin
        pend_d    = pend_q;
        ena_d     = ena_q;
        gie_d     = gie_q;
        rd_data_d = rd_data_q;
        sel_d     = sel_q;
        if (wr_stb && off == OFF_PEND) begin
            pend_d = pend_q & ~bus.DO;
        end
        pend_d = pend_d | src_edge;
        if (wr_stb && off == OFF_ENA) begin
            ena_d = bus.DO;
        end
        if (wr_stb && off == OFF_CTRL) begin
            gie_d = bus.DO[7];
        end
        if (bus.RDY) begin
            sel_d = rd_stb;
            if (rd_stb) begin
                rd_data_d = rd_mux;
            end
        end
        irq_d = gie_q & (|active);
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            src_s1_q  <= 8'h00;
            src_s2_q  <= 8'h00;
            src_s3_q  <= 8'h00;
            pend_q    <= 8'h00;
            ena_q     <= 8'h00;
            gie_q     <= 1'b0;
            rd_data_q <= 8'h00;
            sel_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            src_s1_q  <= SRC;
            src_s2_q  <= src_s1_q;
            src_s3_q  <= src_s2_q;
            pend_q    <= pend_d;
            ena_q     <= ena_d;
            gie_q     <= gie_d;
            rd_data_q <= rd_data_d;
            sel_q     <= sel_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.RD_DATA = rd_data_q;
    assign bus.SEL     = sel_q;
    assign IRQ         = irq_q;

`ifdef IRQ_CTL_NMI_EN
    logic       nmi_s1_q, nmi_s2_q, nmi_s3_q;
    logic [7:0] nmi_cnt_q, nmi_cnt_d;
    logic       nmi_q, nmi_d;
    logic       nmi_load;

    assign nmi_load = (nmi_s2_q & ~nmi_s3_q) |
                      (wr_stb & (off == OFF_CTRL) & bus.DO[0]);

    // NMI output follows the next counter value so the pulse starts on the load edge.
    always_comb begin
        if (nmi_load) begin
            nmi_cnt_d = NMI_LEN;
        end else if (nmi_cnt_q != 8'd0) begin
            nmi_cnt_d = nmi_cnt_q - 8'd1;
        end else begin
            nmi_cnt_d = 8'd0;
        end
        nmi_d = (nmi_cnt_d != 8'd0);
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            nmi_s1_q  <= 1'b0;
            nmi_s2_q  <= 1'b0;
            nmi_s3_q  <= 1'b0;
            nmi_cnt_q <= 8'd0;
            nmi_q     <= 1'b0;
        end else begin
            nmi_s1_q  <= NMI_SRC;
            nmi_s2_q  <= nmi_s1_q;
            nmi_s3_q  <= nmi_s2_q;
            nmi_cnt_q <= nmi_cnt_d;
            nmi_q     <= nmi_d;
        end
    end

    assign NMI = nmi_q;
`else
    logic unused_nmi;
    assign unused_nmi = NMI_SRC ^ (|NMI_LEN);
    assign NMI        = 1'b0;
`endif

endmodule

// File: doc/irq_ctl.md
# irq_ctl

Memory-mapped interrupt controller that sits directly upstream of the 65C02 `cpu` and drives its `IRQ` and `NMI` inputs. It snoops the CPU bus (`AD`, `DO`, `WE`, `RDY`) for accesses to its four registers. It latches rising edges on eight external sources into a pending register and presents a registered read-data byte for the system `DI` mux. It also stretches an external NMI request into a fixed-width pulse.

## Interface
- `BASE`, default 16'hFE00: register base address; must be 4-byte aligned, decoded as `AD[15:2] == BASE[15:2]`.
- `NMI_LEN`, default 8'd4: NMI pulse length in cycles; valid range 1..255; 0 means NMI never asserts.
- `clk` in 1: CPU clock.
- `RST_N` in 1: reset, asynchronous, active-low.
- `AD` in 16: CPU address bus.
- `DO` in 8: CPU write data.
- `WE` in 1: CPU write enable.
- `RDY` in 1: CPU ready; bus accesses count only when `RDY=1`.
- `SRC` in 8: asynchronous interrupt sources, rising-edge sensitive.
- `NMI_SRC` in 1: asynchronous NMI request, rising-edge sensitive.
- `RD_DATA` out 8: registered read data.
- `SEL` out 1: registered; `RD_DATA` is valid and the system must route it to CPU `DI` this cycle.
- `IRQ` out 1: registered, active-high, to CPU `IRQ`.
- `NMI` out 1: registered, active-high, to CPU `NMI`.

## Operation
- Synchronizers: each `SRC[i]` and `NMI_SRC` passes through 2 flops (s1, s2) plus a history flop (s3). An edge is `s2 & ~s3`.
- Register map by offset:
  - 0 `PEND`:
    - read returns the pending bits.
    - write-1-to-clear, per bit.
    - an edge in the same cycle as a clear leaves the bit set.
  - 1 `ENA`: read/write per-source enable.
  - 2 `VEC`:
    - read-only; returns the lowest index i with `PEND[i] & ENA[i]`, as `{5'b0, i}`.
    - returns `8'h80` when no enabled source is pending.
    - writes are ignored.
  - 3 `CTRL`:
    - bit7 = GIE, read/write.
    - bit0 write-1 = software NMI trigger; reads as 0.
    - bits 6..1 read as 0.
- `IRQ` next = `GIE & |(PEND & ENA)`. The controller keeps `IRQ` asserted until software clears the bits via `PEND` or `ENA`.
- NMI counter (8-bit):
  - loads `NMI_LEN` on an NMI_SRC edge or a software trigger.
  - otherwise decrements toward 0 and saturates at 0.
  - `NMI` next = (next counter value != 0).
  - a retrigger while active reloads the counter.
- Read: on a posedge with `RDY & ~WE & hit`, `RD_DATA` captures the addressed register and `SEL` goes to 1. With `RDY=1` and no read hit, `SEL` goes to 0 and `RD_DATA` holds. With `RDY=0`, `RD_DATA` and `SEL` hold.
- Write: takes effect on a posedge with `RDY & WE & hit`.
- Reads have no side effects.
- Reset values: `PEND=0`, `ENA=0`, `GIE=0`, counter 0, all synchronizer flops 0, `RD_DATA=0`, `SEL=0`, `IRQ=0`, `NMI=0`.
- Reset is asynchronous and takes effect mid-operation with no residual edge. After release, a source already high produces an edge once s2 sees it, so pending sets 3 cycles after release.

## Timing
- `SRC` rising edge before posedge e1 gives: s1 set at e1, s2 set at e2, `PEND` bit set at e3, `IRQ=1` at e4 (if enabled and GIE=1).
- Writing 1 to a `PEND` bit or 0 to `ENA` at edge e gives `IRQ=0` at e+1, provided no other enabled source is pending.
- Read address presented in the cycle before edge e gives `RD_DATA`/`SEL` valid from e until the next `RDY` edge: 1-cycle latency, matching a synchronous RAM.
- Read-after-write of the same register in consecutive cycles returns the new value.
- `NMI_SRC` edge: `NMI` rises at e3 and stays high exactly `NMI_LEN` cycles.
- Software trigger written at e gives `NMI` high from e for `NMI_LEN` cycles.

## Configuration
- `IRQ_CTL_NMI_EN`:
  - Defined: the NMI synchronizer, counter and software trigger are built.
  - Undefined: `NMI` is tied 0, `NMI_SRC` is ignored, and `CTRL` bit0 writes are no-ops.
  - `IRQ` behaviour is identical in both builds.

## Test plan
- Reset with `SRC=8'h00`, then pulse `SRC[5]`, `ENA=8'h20`, `GIE=1` -> `PEND=8'h20` at e3, `IRQ=1` at e4, `VEC` reads `8'h05`.
- `SRC[2]` and `SRC[6]` pending, `ENA=8'hFF` -> `VEC=8'h02`; write `PEND=8'h04` -> `VEC=8'h06`, `IRQ` stays 1; write `PEND=8'h40` -> `VEC=8'h80`, `IRQ=0` next cycle.
- `SRC[3]` edge coincident with a W1C write of bit 3 -> `PEND[3]` remains 1.
- Read `CTRL` with `RDY=0` held for 3 cycles -> `SEL` and `RD_DATA` unchanged until `RDY=1`; read with `RDY=1` -> `RD_DATA=8'h80`, `SEL=1` one cycle later.
- With `IRQ_CTL_NMI_EN` and `NMI_LEN=4`: `NMI_SRC` edge -> `NMI` high exactly 4 cycles; retrigger 2 cycles in -> high 6 cycles total. Without the macro, `NMI` stays 0.
- Deassert `RST_N` mid-NMI pulse with `PEND=8'hFF` -> all outputs 0 immediately, with no clock edge needed.
